// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
package uart_pkg;

    typedef enum logic {
        IDLE,
        RECV
    } rcv_state_t;

    // Start + 8 data + stop
    localparam int FRAME_BITS    = 10;
    localparam int BAUD_DIV_9600 = 5208;
    localparam int CNT_W         = 16;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter with a zero flag; paces bit timing for UART RX and TX.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // Load takes priority so a reload on the zero cycle restarts the period cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/uart_rcv.sv
// 8N1 UART receiver: synchronizes RX, mid-bit samples each frame and presents
// the byte through a rdy/clr_rdy handshake with framing and overrun flags.
module uart_rcv
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr
);

    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 1);

    logic             rx_ff1;
    logic             rx_sync;
    logic             rx_prev;
    logic             fall;
    rcv_state_t       state;
    logic [3:0]       bit_cnt;
    logic [8:0]       shift_reg;
    logic             baud_zero;
    logic             baud_load;
    logic [CNT_W-1:0] baud_reload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1  <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_ff1  <= RX;
            rx_sync <= rx_ff1;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev & ~rx_sync;

    // First load lands on the start-bit middle, later loads span a full bit
    always_comb begin
        baud_load   = 1'b0;
        baud_reload = CNT_W'(BAUD_DIV - 1);
        if (state == IDLE) begin
            baud_load   = fall;
            baud_reload = CNT_W'(HALF_DIV - 1);
        end else begin
            baud_load   = baud_zero;
        end
    end

    uart_baud_cnt #(
        .W(CNT_W)
    ) u_baud_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (baud_load),
        .load_val(baud_reload),
        .en      (state == RECV),
        .zero    (baud_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= 8'h00;
            rdy       <= 1'b0;
            frm_err   <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rdy     <= 1'b0;
                frm_err <= 1'b0;
                ovr     <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (fall) begin
                        bit_cnt <= '0;
                        state   <= RECV;
                    end
                end
                RECV: begin
                    if (baud_zero) begin
                        shift_reg <= {rx_sync, shift_reg[8:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd0 && rx_sync) begin
                            state <= IDLE;
                        end else if (bit_cnt == STOP_IDX) begin
                            state <= IDLE;
                            // Data bits sit above the start bit until the stop sample
                            if (rx_sync) begin
                                rx_data <= shift_reg[8:1];
                                rdy     <= 1'b1;
                                frm_err <= 1'b0;
                                ovr     <= rdy & ~clr_rdy;
                            end else begin
                                frm_err <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rcv.sv
// Self-checking bench for uart_rcv: directed scenarios plus random frames,
// compared every cycle against a frame-level timing model.
module tb_uart_rcv;

    localparam int BAUD = 16;
    localparam int HALF = BAUD / 2;

    logic       clk;
    logic       rst_n;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr;

    int checks   = 0;
    int failures = 0;

    uart_rcv #(
        .BAUD_DIV(BAUD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .RX     (RX),
        .clr_rdy(clr_rdy),
        .rx_data(rx_data),
        .rdy    (rdy),
        .frm_err(frm_err),
        .ovr    (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: line pipeline plus frame position in absolute cycles
    int         mcyc = 0;
    logic       m_ff1, m_sync, m_prev;
    bit         m_busy;
    int         m_t0;
    logic [7:0] m_byte;
    logic [7:0] m_data;
    logic       m_rdy, m_frm, m_ovr;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_ff1  = 1'b1;
        m_sync = 1'b1;
        m_prev = 1'b1;
        m_busy = 1'b0;
        m_t0   = 0;
        m_byte = 8'h00;
        m_data = 8'h00;
        m_rdy  = 1'b0;
        m_frm  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_step();
        bit fall;
        bit old_rdy;
        int d;
        int k;
        fall    = m_prev && !m_sync;
        old_rdy = m_rdy;
        if (clr_rdy) begin
            m_rdy = 1'b0;
            m_frm = 1'b0;
            m_ovr = 1'b0;
        end
        if (!m_busy) begin
            if (fall) begin
                m_busy = 1'b1;
                m_t0   = mcyc;
            end
        end else begin
            d = mcyc - m_t0 - HALF;
            if (d >= 0 && (d % BAUD) == 0) begin
                k = d / BAUD;
                if (k == 0) begin
                    if (m_sync) m_busy = 1'b0;
                end else if (k <= 8) begin
                    m_byte[k-1] = m_sync;
                end else begin
                    m_busy = 1'b0;
                    if (m_sync) begin
                        m_data = m_byte;
                        m_rdy  = 1'b1;
                        m_frm  = 1'b0;
                        m_ovr  = old_rdy && !clr_rdy;
                    end else begin
                        m_frm = 1'b1;
                    end
                end
            end
        end
        m_prev = m_sync;
        m_sync = m_ff1;
        m_ff1  = RX;
        mcyc++;
    endtask

    // Inputs change just after posedge, so the negedge sees what the next edge samples
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        checkOutput("cyc_rx_data", rx_data, m_data);
        checkOutput("cyc_rdy", rdy, m_rdy);
        checkOutput("cyc_frm_err", frm_err, m_frm);
        checkOutput("cyc_ovr", ovr, m_ovr);
        if (rst_n) model_step();
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input int clr_idx);
        RX = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = data[i];
            tick(BAUD);
        end
        RX = stop_bit;
        for (int i = 0; i < BAUD; i++) begin
            clr_rdy = (i == clr_idx);
            tick(1);
        end
        clr_rdy = 1'b0;
        RX      = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] rb;
        model_reset();
        rst_n   = 1'b0;
        RX      = 1'b1;
        clr_rdy = 1'b0;
        tick(3);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rdy", rdy, 1'b0);
        checkOutput("reset_frm_err", frm_err, 1'b0);
        checkOutput("reset_ovr", ovr, 1'b0);
        rst_n = 1'b1;
        tick(10);

        // 2 sync stages + 1 + HALF + 9*BAUD + 1 negedges from driving the start bit
        n = 0;
        fork
            applyStimulus(8'hA5, 1'b1, -1);
            begin
                while (n < 400 && !rdy) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        checkOutput("a5_rdy_latency", n, 156);
        checkOutput("a5_rx_data", rx_data, 8'hA5);
        checkOutput("a5_model_data", m_data, 8'hA5);
        checkOutput("a5_frm_err", frm_err, 1'b0);
        checkOutput("a5_ovr", ovr, 1'b0);
        pulse_clr();
        tick(4);

        applyStimulus(8'h3C, 1'b1, -1);
        tick(2);
        checkOutput("3c_rx_data", rx_data, 8'h3C);
        checkOutput("3c_rdy", rdy, 1'b1);
        pulse_clr();
        checkOutput("3c_clr_rdy", rdy, 1'b0);
        checkOutput("3c_hold_data", rx_data, 8'h3C);
        tick(5);

        applyStimulus(8'hFF, 1'b1, -1);
        checkOutput("ff_rx_data", rx_data, 8'hFF);
        fork
            applyStimulus(8'h00, 1'b1, -1);
            begin
                tick(20);
                pulse_clr();
            end
        join
        checkOutput("b2b_rx_data", rx_data, 8'h00);
        checkOutput("b2b_rdy", rdy, 1'b1);
        checkOutput("b2b_ovr", ovr, 1'b0);

        RX = 1'b0;
        tick(5);
        RX = 1'b1;
        tick(40);
        checkOutput("glitch_rx_data", rx_data, 8'h00);
        checkOutput("glitch_rdy", rdy, 1'b1);
        checkOutput("glitch_frm_err", frm_err, 1'b0);

        pulse_clr();
        applyStimulus(8'h81, 1'b0, -1);
        tick(2);
        checkOutput("frm_frm_err", frm_err, 1'b1);
        checkOutput("frm_rdy", rdy, 1'b0);
        checkOutput("frm_rx_data", rx_data, 8'h00);
        pulse_clr();
        checkOutput("frm_cleared", frm_err, 1'b0);
        tick(5);

        applyStimulus(8'h11, 1'b1, -1);
        tick(3);
        applyStimulus(8'h22, 1'b1, -1);
        tick(2);
        checkOutput("ovr_rx_data", rx_data, 8'h22);
        checkOutput("ovr_rdy", rdy, 1'b1);
        checkOutput("ovr_flag", ovr, 1'b1);
        applyStimulus(8'h33, 1'b1, HALF + 2);
        tick(1);
        checkOutput("setwin_rx_data", rx_data, 8'h33);
        checkOutput("setwin_rdy", rdy, 1'b1);
        checkOutput("setwin_ovr", ovr, 1'b0);

        // Abort a frame of 0xC3 after its fifth sample
        RX = 1'b0;
        tick(BAUD);
        rb = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            RX = rb[i];
            tick(BAUD);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_rx_data", rx_data, 8'h00);
        checkOutput("abort_rdy", rdy, 1'b0);
        checkOutput("abort_ovr", ovr, 1'b0);
        RX = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        applyStimulus(8'h5A, 1'b1, -1);
        tick(2);
        checkOutput("post_reset_data", rx_data, 8'h5A);
        checkOutput("post_reset_rdy", rdy, 1'b1);
        checkOutput("post_reset_frm", frm_err, 1'b0);
        checkOutput("post_reset_ovr", ovr, 1'b0);

        for (int f = 0; f < 12; f++) begin
            rb = 8'($urandom_range(0, 255));
            applyStimulus(rb, ($urandom_range(0, 5) != 0), int'($urandom_range(0, BAUD * 2)));
            if ($urandom_range(0, 1) == 1) tick(int'($urandom_range(1, 20)));
            if ($urandom_range(0, 2) == 0) pulse_clr();
        end
        tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rcv.md
Name: uart_rcv

Overview:
- 8N1 UART receiver consuming the serial line driven by the UART transmitter in the UART bring-up top.
- Recovers bytes for display on LEDs[7:0].
- Synchronizes the asynchronous RX pin, detects the start bit, mid-bit samples 8 data bits LSB-first plus stop, and presents the byte with a rdy/clr_rdy handshake.
- Also flags framing errors and overruns.

Parameters:
- BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600 baud). Legal range 4..65535.
- HALF_DIV, BAUD_DIV/2, cycles from start-edge detection to start-bit mid-sample. Integer floor.

Ports:
- clk  input  1  system clock, 50 MHz, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset (already synchronized upstream by reset_synch).
- RX  input  1  asynchronous serial line, idle high.
- clr_rdy  input  1  consumer acknowledge; clears rdy, frm_err and ovr.
- rx_data  output  8  last received byte.
- rdy  output  1  high while rx_data holds an unacknowledged valid byte.
- frm_err  output  1  stop bit sampled low on last frame.
- ovr  output  1  a new byte completed while rdy was still high.

Behaviour:
- Reset (rst_n low, async) forces the following:
  - Both RX synchronizer flops to 1.
  - rx_data=8'h00; rdy=0; frm_err=0; ovr=0.
  - State IDLE; baud counter=0; bit counter=0; shift register=0.
- RX passes through 2 flops (rx_ff1, rx_sync); a third flop (rx_prev) provides falling-edge detect: fall = rx_prev & ~rx_sync.
- States:
  - IDLE: on fall, load baud_cnt=HALF_DIV-1, bit_cnt=0, go RECV. Otherwise stay.
  - RECV: baud_cnt decrements each cycle. When baud_cnt==0 it is a sample event:
    - Shift rx_sync into the shift register MSB (right shift).
    - Increment bit_cnt.
    - Reload baud_cnt=BAUD_DIV-1.
  - Sample 0 (start): if rx_sync==1, false start. Return to IDLE with no output change.
  - Sample 9 (stop), state returns to IDLE:
    - If rx_sync==1, then on the next edge: rx_data=shift[7:0]; rdy=1; frm_err=0; ovr=rdy_old.
    - If rx_sync==0: frm_err=1; rx_data and rdy unchanged.
- Timing: with the fall detected in cycle T0, sample k occurs at cycle T0+HALF_DIV+k*BAUD_DIV, for k=0..9. rdy rises at T0+HALF_DIV+9*BAUD_DIV+1.
- A new start edge is not accepted until IDLE is reached after the stop sample. Back-to-back frames with zero idle are supported because the stop mid-sample precedes the next start edge by about BAUD_DIV/2.
- clr_rdy high for one or more cycles clears rdy, frm_err and ovr on the next edge. rx_data is held.
- If clr_rdy coincides with a completing frame, the set wins: rdy=1, ovr=0.
- Overrun: the new byte overwrites rx_data and ovr=1.
- RX glitches shorter than HALF_DIV are rejected by the start-bit re-check.
- Async reset mid-frame aborts immediately. The first frame after reset release requires a fresh falling edge.

Decomposition:
- Shared package uart_pkg:
  - State enum {IDLE, RECV}.
  - Constant FRAME_BITS=10.
  - Default baud divisor constant BAUD_DIV_9600=5208. The transmitter uses the same constant.
- One natural sub-module: uart_baud_cnt, a loadable down-counter with reload value and zero flag. It is reusable by the transmitter.
- The synchronizer stays inline.

Test Plan:
- BAUD_DIV=16. Drive frame 0xA5 (LSB-first: 1,0,1,0,0,1,0,1, stop 1) after idle -> rdy rises exactly HALF_DIV+9*16+1 cycles after the fall is seen at rx_sync; rx_data=8'hA5; frm_err=0; ovr=0.
- Send 0x3C. Pulse clr_rdy for 1 cycle -> rdy=0 next cycle, rx_data stays 8'h3C. Then send 0xFF, 0x00 back-to-back with no idle -> both received in order, one clr_rdy between.
- RX low glitch of 5 cycles, then idle high -> state returns to IDLE at the start sample; rdy, rx_data and flags unchanged.
- Frame 0x81 with stop bit driven 0 -> frm_err=1, rdy stays 0, rx_data keeps previous value. clr_rdy clears frm_err.
- Send 0x11 without clr_rdy, then 0x22 -> rx_data=8'h22, rdy=1, ovr=1. Assert clr_rdy on the exact completion cycle of a third frame 0x33 -> rdy=1, ovr=0.
- Assert rst_n low mid-frame after sample 4 -> outputs zero asynchronously. Release and send 0x5A -> received correctly, with no residue from the aborted frame.
